// File: rtl/fuse_read_arbiter_pkg.sv
// Shared types and helpers for the fuse read arbiter: FSM state encoding and
// the owner index width calculation used by the top and the round-robin picker.
package fuse_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Keeps the index at least one bit wide even for a degenerate single requester.
    function automatic int owner_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fuse_read_arbiter_if.sv
// Requester-side bus of the fuse read arbiter: level requests with per-requester
// fuse index in, one-hot grant/response pulses and shared response data out.
interface fuse_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]                 req_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ-1:0]                 gnt_o;
    logic [NUM_REQ-1:0]                 rvalid_o;
    logic                               err_o;
    logic [DATA_WIDTH-1:0]              rdata_o;

    modport master (
        output req_i,
        output addr_i,
        input  gnt_o,
        input  rvalid_o,
        input  err_o,
        input  rdata_o
    );

    modport slave (
        input  req_i,
        input  addr_i,
        output gnt_o,
        output rvalid_o,
        output err_o,
        output rdata_o
    );

endinterface

// File: rtl/fuse_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping, returned as one-hot, index and a valid flag.
module fuse_rr_pick
    import fuse_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        int cand;
        cand   = 0;
        idx    = '0;
        valid  = 1'b0;
        onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req[cand]) begin
                idx   = IDX_W'(cand);
                valid = 1'b1;
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fuse_read_arbiter.sv
// Round-robin arbiter sharing the single-ported fuse memory among NUM_REQ
// requesters, one outstanding read at a time, with fuse index range checking.
module fuse_read_arbiter
    import fuse_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FUSE_MEM_SIZE = 34,
    parameter int RD_LATENCY    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fuse_read_arbiter_if.slave    bus,
    output logic                  fuse_req_o,
    output logic [ADDR_WIDTH-1:0] fuse_addr_o,
    input  logic [DATA_WIDTH-1:0] fuse_rdata_i
);

    localparam int IDX_W = owner_width(NUM_REQ);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oor;

    fuse_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign sel_addr = bus.addr_i[pick_idx];
    assign sel_oor  = (sel_addr >= ADDR_WIDTH'(FUSE_MEM_SIZE));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = sel_oor ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is gated by reset so a held request cannot pulse gnt while reset is asserted.
    always_comb begin
        bus.gnt_o    = '0;
        bus.rvalid_o = '0;
        bus.err_o    = 1'b0;
        fuse_req_o   = 1'b0;
        if (state_q == IDLE && rst_ni) begin
            bus.gnt_o = pick_onehot;
        end
        if (state_q == ISSUE) begin
            fuse_req_o = 1'b1;
        end
        if (state_q == RESP) begin
            bus.rvalid_o[owner_q] = 1'b1;
            bus.err_o             = err_q;
        end
    end

    assign bus.rdata_o = data_q;
    assign fuse_addr_o = addr_q;

    // addr_q only loads for in-range grants so fuse_addr_o keeps the last issued index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        ptr_q   <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                        err_q   <= sel_oor;
                        if (sel_oor) begin
                            data_q <= '0;
                        end else begin
                            addr_q <= sel_addr;
                        end
                    end
                end
                ISSUE: cnt_q <= CNT_W'(RD_LATENCY - 1);
                WAIT: begin
                    if (cnt_q == '0) begin
                        data_q <= fuse_rdata_i;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
